// File: rtl/decode_fetch_sequencer.sv
// Byte-stream front end: buffers upstream bytes, exposes a 9-byte decode window,
// and issues each decoded instruction downstream over a valid/ready handshake.
module decode_fetch_sequencer #(
    parameter int BUF_BYTES = 16,
    parameter int WIN_BYTES = 9,
    parameter int IN_BYTES  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_BYTES*8-1:0]  in_data,
    input  logic [2:0]             in_bytes,
    input  logic                   in_last,
    output logic [WIN_BYTES*8-1:0] dec_window,
    input  logic [3:0]             dec_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIN_BYTES*8-1:0] out_instr,
    output logic [3:0]             out_len,
    output logic                   done,
    output logic                   err
);
    localparam int CW = $clog2(BUF_BYTES + 1);
    localparam int BW = BUF_BYTES * 8;
    localparam int WW = WIN_BYTES * 8;
    localparam int IW = IN_BYTES * 8;

    typedef enum logic [1:0] {FILL, PRESENT, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] count_q, count_d;
    logic          eos_q, eos_d;
    logic          out_valid_q, out_valid_d;
    logic [WW-1:0] out_instr_q, out_instr_d;
    logic [3:0]    out_len_q, out_len_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept, beat_ok, retire, trigger, len_bad;
    logic [3:0]    shift_len;
    logic [CW-1:0] base;
    logic [IW-1:0] in_masked;
    logic [BW-1:0] shifted;

    always_comb begin
        dec_window = '0;
        for (int i = 0; i < WIN_BYTES; i++)
            dec_window[i*8 +: 8] = (i < int'(count_q)) ? buf_q[i*8 +: 8] : 8'h00;
    end

    assign in_ready = rst_n && !flush && (state_q == FILL || state_q == PRESENT) && !eos_q
                      && (int'(count_q) + IN_BYTES <= BUF_BYTES);

    // Retire and append in one step: the new beat lands right after the bytes that survive the shift.
    always_comb begin
        accept    = in_valid && in_ready;
        beat_ok   = (in_bytes != 3'd0) && (int'(in_bytes) <= IN_BYTES);
        retire    = (state_q == PRESENT) && out_valid_q && out_ready;
        shift_len = retire ? out_len_q : 4'd0;
        base      = count_q - CW'(shift_len);
        shifted   = buf_q >> {shift_len, 3'b000};
        in_masked = '0;
        for (int i = 0; i < IN_BYTES; i++)
            if (i < int'(in_bytes))
                in_masked[i*8 +: 8] = in_data[i*8 +: 8];
        buf_d   = shifted;
        count_d = base;
        if (accept && beat_ok) begin
            buf_d   = shifted | (BW'(in_masked) << {base, 3'b000});
            count_d = base + CW'(in_bytes);
        end
        eos_d = eos_q || (accept && in_last);
    end

    always_comb begin
        trigger     = (int'(count_q) >= WIN_BYTES) || (eos_q && count_q != '0);
        len_bad     = (dec_len == 4'd0) || (int'(dec_len) > WIN_BYTES)
                      || (int'(dec_len) > int'(count_q));
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_len_d   = out_len_q;
        done_d      = done_q;
        err_d       = err_q;
        case (state_q)
            FILL: begin
                if (eos_q && count_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (trigger) begin
                    if (len_bad) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = PRESENT;
                        out_valid_d = 1'b1;
                        out_instr_d = dec_window;
                        out_len_d   = dec_len;
                    end
                end
            end
            PRESENT: begin
                if (retire) begin
                    out_valid_d = 1'b0;
                    state_d     = FILL;
                end
            end
            default: ;
        endcase
    end

    // Flush has the same effect as reset but is sampled on the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            buf_q       <= '0;
            count_q     <= '0;
            eos_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_len_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (flush) begin
            state_q     <= FILL;
            buf_q       <= '0;
            count_q     <= '0;
            eos_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_len_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            eos_q       <= eos_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_len_q   <= out_len_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_len   = out_len_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/decode_fetch_sequencer.md
Name: decode_fetch_sequencer

Overview:
- Byte-stream front end for operand/length decode: buffers raw instruction bytes and presents a 72-bit (9-byte) window to the combinational decode/length logic.
- Registers each decoded instruction and hands it downstream over a valid/ready handshake.
- Retires the consumed bytes and refills from an upstream 32-bit word stream.
- Sits between the instruction-byte source and the per-instruction decode/execute circuit.

Parameters:
- BUF_BYTES, 16, byte capacity of the internal shift buffer; must be ≥ WIN_BYTES + IN_BYTES - 1.
- WIN_BYTES, 9, bytes in the decode window; the window is fixed at 72 bits.
- IN_BYTES, 4, maximum bytes per upstream beat.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all state; highest priority.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  sequencer can accept a beat this cycle.
- in_data  in  32  upstream bytes, first byte in [7:0].
- in_bytes  in  3  valid bytes in in_data, 1..4.
- in_last  in  1  beat is the final beat of the stream.
- dec_window  out  72  buffer bytes 0..8, byte 0 in [7:0]; bytes at or beyond count are zero.
- dec_len  in  4  instruction length from the comb decode of dec_window; sampled only in FILL.
- out_valid  out  1  registered instruction available.
- out_ready  in  1  downstream accepts.
- out_instr  out  72  registered window of the presented instruction.
- out_len  out  4  registered length.
- done  out  1  stream fully consumed.
- err  out  1  sticky length error.

Behaviour:
- Reset (rst_n low, async) and flush:
  - state=FILL; count=0; eos=0; buffer zeroed.
  - out_valid=0, out_instr=0, out_len=0, done=0, err=0, in_ready=0.
  - flush forces in_ready=0 in the flush cycle.
- Input handshake:
  - in_ready = state∈{FILL,PRESENT} && !eos && count+IN_BYTES ≤ BUF_BYTES, evaluated on the pre-shift count.
  - A beat transfers when in_valid && in_ready.
  - Its in_bytes bytes are written at buffer index count' (see simultaneous accept below); count' += in_bytes.
  - in_last sets eos.
  - in_bytes=0 or >4 with in_valid: beat is accepted and its bytes are ignored; in_last is still honoured.
- States:
  - FILL: decode trigger = count ≥ WIN_BYTES || (eos && count>0).
    - On trigger, dec_len is checked. If dec_len==0, dec_len>WIN_BYTES, or dec_len>count: go to ERR.
    - Otherwise latch out_instr=dec_window and out_len=dec_len, set out_valid=1, go to PRESENT. The instruction appears one cycle after the trigger condition first holds.
    - If eos && count==0: go to DONE.
  - PRESENT:
    - out_valid, out_instr, out_len are held stable until out_ready.
    - On out_valid && out_ready: buffer shifts down by out_len bytes, count -= out_len, out_valid=0, go to FILL.
    - Minimum issue interval is 2 cycles per instruction.
  - DONE: done=1, in_ready=0; state held until flush/reset.
  - ERR: err=1, in_ready=0, out_valid=0; state held until flush/reset.
- Simultaneous accept: an input beat in the same cycle as an out handshake is written at index count-out_len. Shift and append are applied together; no byte is lost or duplicated.
- Byte ordering: buffer index 0 is always the oldest unconsumed byte. Shifted-in vacant positions are zero.
- Invariant: count ≤ BUF_BYTES at all times.
- Boundary cases:
  - eos with count<9: the window is zero-padded above count, and a partial window may decode.
  - A final instruction exactly consuming all bytes leads to DONE after the following FILL cycle.
  - Reset asserted mid-PRESENT drops the held instruction.

Test Plan:
- Byte stream 90 | 89 D8 | 8B 44 24 08 as one 4-byte beat then a 3-byte last beat; bench returns dec_len 1, 2, 4 from the window; out_ready=1 → three out handshakes with out_len 1, 2, 4 and out_instr[7:0]=90, then D889, then 0824448B; then done=1.
- Hold out_ready=0 for 5 cycles in PRESENT → out_instr/out_len stable and in_ready drops once count+4>16; release → shift plus same-cycle beat keeps bytes contiguous, and the next out_instr[7:0] equals the byte following the retired instruction.
- Single 3-byte last beat and dec_len=4 → err=1 the cycle after the trigger, out_valid never asserts, in_ready=0; flush → err=0, count=0, in_ready=1.
- dec_len=0 and, separately, dec_len=10 with count≥9 → ERR in both cases.
- rst_n pulled low asynchronously mid-PRESENT → outputs zero immediately with no clock edge; after release a fresh stream decodes from byte 0.
- 16 one-byte-length instructions streamed at full rate → exactly 16 handshakes, bytes in order, done=1 and count=0 at end.
